// File: rtl/sipo4_feeder_pkg.sv
// Shared constants for the 4-bit serial-in/parallel-out feeder.
package sipo4_feeder_pkg;

  localparam int unsigned SIPO_W     = 4;
  localparam logic [2:0]  FILL_MAX   = 3'd4;
  localparam logic [2:0]  FILL_EMPTY = 3'd0;

endpackage

// File: rtl/sipo4_feeder_if.sv
// Bus between the feeder and its parent.
//   master: drives din, shift_en, clr, load, load_val; observes q0..q3, fill_cnt, full, din_db
//   slave : the feeder side of the same signals
interface sipo4_feeder_if;
  import sipo4_feeder_pkg::*;

  logic              din;
  logic              shift_en;
  logic              clr;
  logic              load;
  logic [SIPO_W-1:0] load_val;
  logic              q0;
  logic              q1;
  logic              q2;
  logic              q3;
  logic [2:0]        fill_cnt;
  logic              full;
  logic              din_db;

  modport master (
    output din, shift_en, clr, load, load_val,
    input  q0, q1, q2, q3, fill_cnt, full, din_db
  );

  modport slave (
    input  din, shift_en, clr, load, load_val,
    output q0, q1, q2, q3, fill_cnt, full, din_db
  );

endinterface

// File: rtl/sipo4_feeder_din_debounce.sv
// Two-flop synchroniser followed by a stability counter on the raw serial input.
//   clk, rst_n : clock, async active-low reset
//   din_i      : raw asynchronous input
//   din_db_o   : debounced value, updates after DB_CYCLES stable clocks at the sync output
module sipo4_feeder_din_debounce #(
  parameter int unsigned DB_CYCLES = 3,
  parameter int unsigned DB_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic din_db_o
);

  logic            s1_q, s2_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic [DB_W-1:0] cnt_inc;

  // Registers: synchroniser chain, counter, debounced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      s1_q  <= din_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign cnt_inc = DB_W'(cnt_q + DB_W'(1));

  // Count clocks of disagreement; any agreement restarts the count
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_inc == DB_W'(DB_CYCLES)) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  assign din_db_o = db_q;

endmodule

// File: rtl/sipo4_feeder.sv
// Serial-in/parallel-out feeder for a downstream 4-input AND stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of sipo4_feeder_if (strobes, load value, q0..q3,
//                fill count, full flag, debounced input)
module sipo4_feeder
  import sipo4_feeder_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 3,
  parameter int unsigned DB_W      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sipo4_feeder_if.slave  bus
);

  logic              din_db;
  logic [SIPO_W-1:0] q_q, q_d;
  logic [2:0]        fill_q, fill_d;
  logic              full_q, full_d;

  sipo4_feeder_din_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_din_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_i    (bus.din),
    .din_db_o (din_db)
  );

  // State register: shift register, fill count (EMPTY/FILLING/FULL) and full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      fill_q <= FILL_EMPTY;
      full_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      fill_q <= fill_d;
      full_q <= full_d;
    end
  end

  // Next state with clr > load > shift_en priority; fill count saturates at FULL
  always_comb begin
    q_d    = q_q;
    fill_d = fill_q;
    if (bus.clr) begin
      q_d    = '0;
      fill_d = FILL_EMPTY;
    end else if (bus.load) begin
      q_d    = bus.load_val;
      fill_d = FILL_MAX;
    end else if (bus.shift_en) begin
      q_d = {q_q[SIPO_W-2:0], din_db};
      if (fill_q != FILL_MAX) begin
        fill_d = 3'(fill_q + 3'd1);
      end
    end
    // Flag derived from the next count so it lands on the same edge as the count
    full_d = (fill_d == FILL_MAX);
  end

  // Outputs straight from registers
  always_comb begin
    bus.q0       = q_q[0];
    bus.q1       = q_q[1];
    bus.q2       = q_q[2];
    bus.q3       = q_q[3];
    bus.fill_cnt = fill_q;
    bus.full     = full_q;
    bus.din_db   = din_db;
  end

endmodule

// File: tb/tb_sipo4_feeder.sv
// Directed self-checking bench for sipo4_feeder (default DB_CYCLES = 3).
module tb_sipo4_feeder;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  sipo4_feeder_if bus_if ();

  sipo4_feeder #(
    .DB_CYCLES (3),
    .DB_W      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] qv();
    return {bus_if.q3, bus_if.q2, bus_if.q1, bus_if.q0};
  endfunction

  // Advance one clock and sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive din and wait (bounded) for the debounced value to follow
  task automatic set_db(input logic val);
    bus_if.din = val;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_if.din_db === val) break;
    end
    checks++;
    if (bus_if.din_db !== val) begin
      errors++;
      $display("FAIL set_db: din_db=%b required=%b", bus_if.din_db, val);
    end
  endtask

  task automatic shift_one();
    bus_if.shift_en = 1'b1;
    step();
    bus_if.shift_en = 1'b0;
  endtask

  task automatic clr_one();
    bus_if.clr = 1'b1;
    step();
    bus_if.clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.din = 1'b0; bus_if.shift_en = 1'b0; bus_if.clr = 1'b0;
    bus_if.load = 1'b0; bus_if.load_val = 4'b0000;
    #1;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({qv(), bus_if.fill_cnt, bus_if.full, bus_if.din_db} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: q=%b fill=%0d full=%b db=%b required all 0",
               qv(), bus_if.fill_cnt, bus_if.full, bus_if.din_db);
    end
  endtask

  task automatic test_debounce();
    // 2-clock glitch must not propagate
    bus_if.din = 1'b1;
    step();
    step();
    bus_if.din = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (bus_if.din_db !== 1'b0) begin
        errors++;
        $display("FAIL db_glitch[%0d]: din_db=%b required=0", i, bus_if.din_db);
      end
    end
    // Clean edge: din_db rises on the 5th edge after din changes
    bus_if.din = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (bus_if.din_db !== (i == 5)) begin
        errors++;
        $display("FAIL db_latency[edge %0d]: din_db=%b required=%b", i, bus_if.din_db, (i == 5));
      end
    end
  endtask

  task automatic test_fill();
    logic [2:0] exp_fill;
    clr_one();
    bus_if.shift_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_fill = (i >= 4) ? 3'd4 : 3'(i);
      checks++;
      if (bus_if.fill_cnt !== exp_fill || bus_if.full !== (i >= 4)) begin
        errors++;
        $display("FAIL fill[%0d]: fill=%0d full=%b required fill=%0d full=%b",
                 i, bus_if.fill_cnt, bus_if.full, exp_fill, (i >= 4));
      end
    end
    bus_if.shift_en = 1'b0;
    checks++;
    if (qv() !== 4'b1111 || (&qv()) !== 1'b1) begin
      errors++;
      $display("FAIL fill_and: q=%b and=%b required q=1111 and=1", qv(), &qv());
    end
  endtask

  task automatic test_shift_order();
    clr_one();
    set_db(1'b1); shift_one();
    set_db(1'b0); shift_one();
    set_db(1'b1); shift_one();
    shift_one();
    checks++;
    if (qv() !== 4'b1011 || bus_if.full !== 1'b1 || bus_if.fill_cnt !== 3'd4 || (&qv()) !== 1'b0) begin
      errors++;
      $display("FAIL shift_order: q=%b full=%b fill=%0d and=%b required q=1011 full=1 fill=4 and=0",
               qv(), bus_if.full, bus_if.fill_cnt, &qv());
    end
  endtask

  task automatic test_priority();
    bus_if.clr = 1'b1; bus_if.load = 1'b1; bus_if.shift_en = 1'b1;
    bus_if.load_val = 4'b0110;
    step();
    checks++;
    if (qv() !== 4'b0000 || bus_if.fill_cnt !== 3'd0 || bus_if.full !== 1'b0) begin
      errors++;
      $display("FAIL prio_clr: q=%b fill=%0d full=%b required q=0000 fill=0 full=0",
               qv(), bus_if.fill_cnt, bus_if.full);
    end
    bus_if.clr = 1'b0;
    step();
    checks++;
    if (qv() !== 4'b0110 || bus_if.fill_cnt !== 3'd4 || bus_if.full !== 1'b1) begin
      errors++;
      $display("FAIL prio_load: q=%b fill=%0d full=%b required q=0110 fill=4 full=1",
               qv(), bus_if.fill_cnt, bus_if.full);
    end
    bus_if.load = 1'b0; bus_if.shift_en = 1'b0;
  endtask

  task automatic test_saturate_clear();
    bus_if.shift_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus_if.fill_cnt !== 3'd4 || bus_if.full !== 1'b1) begin
        errors++;
        $display("FAIL sat[%0d]: fill=%0d full=%b required fill=4 full=1", i, bus_if.fill_cnt, bus_if.full);
      end
    end
    bus_if.shift_en = 1'b0;
    clr_one();
    checks++;
    if (bus_if.fill_cnt !== 3'd0 || bus_if.full !== 1'b0 || qv() !== 4'b0000) begin
      errors++;
      $display("FAIL sat_clr: fill=%0d full=%b q=%b required fill=0 full=0 q=0000",
               bus_if.fill_cnt, bus_if.full, qv());
    end
  endtask

  task automatic test_reset_midop();
    set_db(1'b1); shift_one();
    set_db(1'b0); shift_one();
    set_db(1'b1); shift_one();
    checks++;
    if (qv() !== 4'b0101 || bus_if.fill_cnt !== 3'd3) begin
      errors++;
      $display("FAIL midop_pre: q=%b fill=%0d required q=0101 fill=3", qv(), bus_if.fill_cnt);
    end
    // Assert reset between edges while shifting
    bus_if.shift_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({qv(), bus_if.fill_cnt, bus_if.full, bus_if.din_db} !== 9'b0) begin
      errors++;
      $display("FAIL midop_async: q=%b fill=%0d full=%b db=%b required all 0",
               qv(), bus_if.fill_cnt, bus_if.full, bus_if.din_db);
    end
    step();
    step();
    bus_if.shift_en = 1'b0;
    bus_if.din = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({qv(), bus_if.fill_cnt, bus_if.full, bus_if.din_db} !== 9'b0) begin
      errors++;
      $display("FAIL midop_release: q=%b fill=%0d full=%b db=%b required all 0",
               qv(), bus_if.fill_cnt, bus_if.full, bus_if.din_db);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_debounce();
    test_fill();
    test_shift_order();
    test_priority();
    test_saturate_clear();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
